mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 130 +++++++++++++
 tb/tb_mem_access_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit with byte/halfword/word access, sub-word stores done as read-modify-write on a word-wide memory.
// Latency: fault 1, load/word store 2, sub-word store 3 cycles after acceptance; accepts only in IDLE, response has no back-pressure.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_WIDTH+1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_misaligned,
    output logic                  o_mem_wenable,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, uns_q, fault_q;
    logic [1:0]            size_q, off_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rword_q;

    logic                  accept, req_fault;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] load_v, merged;

    assign accept = i_req_valid && (state_q == IDLE);

    always_comb begin
        req_fault = 1'b0;
        case (i_req_size)
            SZ_HALF: req_fault = i_req_addr[0];
            SZ_WORD: req_fault = (i_req_addr[1:0] != 2'b00);
            SZ_BYTE: req_fault = 1'b0;
            default: req_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            rword_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= i_req_we;
                uns_q   <= i_req_unsigned;
                fault_q <= req_fault;
                size_q  <= i_req_size;
                off_q   <= i_req_addr[1:0];
                waddr_q <= i_req_addr[ADDR_WIDTH+1:2];
                wdata_q <= i_req_wdata;
            end
            if (state_q == READ) begin
                rword_q <= i_mem_rdata;
            end
        end
    end

    // Sub-word stores need the old word first, so they go through READ before WRITE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_fault)
                        state_d = RESP;
                    else if (i_req_we && (i_req_size == SZ_WORD))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_v = rword_q[{off_q, 3'b000} +: 8];
        half_v = rword_q[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: load_v = {{24{~uns_q & byte_v[7]}}, byte_v};
            SZ_HALF: load_v = {{16{~uns_q & half_v[15]}}, half_v};
            default: load_v = rword_q;
        endcase
    end

    always_comb begin
        merged = rword_q;
        case (size_q)
            SZ_BYTE: merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
            SZ_HALF: merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    assign o_req_ready   = (state_q == IDLE);
    assign o_resp_valid  = (state_q == RESP);
    assign o_misaligned  = (state_q == RESP) && fault_q;
    assign o_resp_rdata  = ((state_q == RESP) && !fault_q && !we_q) ? load_v : '0;
    assign o_mem_wenable = (state_q == WRITE);
    assign o_mem_address = ((state_q == READ) || (state_q == WRITE)) ? waddr_q : '0;
    assign o_mem_wdata   = (state_q == WRITE) ? merged : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a word-wide model memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, misaligned, mem_wenable;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_address;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] r_rdata, r_wdata;
    logic        r_mis;
    logic [7:0]  r_waddr;
    int          r_lat, r_wcnt, r_wcyc, r_stray;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_size    (req_size),
        .i_req_unsigned(req_unsigned),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_resp_valid  (resp_valid),
        .o_resp_rdata  (resp_rdata),
        .o_misaligned  (misaligned),
        .o_mem_wenable (mem_wenable),
        .o_mem_address (mem_address),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    assign mem_rdata = mem[mem_address];

    always @(posedge clk) begin
        if (mem_wenable)
            mem[mem_address] <= mem_wdata;
        else if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Issues one request, scrambles the inputs right after acceptance, then watches up to 10 cycles.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = ~wd;
        r_lat = -1; r_wcnt = 0; r_wcyc = -1; r_stray = 0;
        r_rdata = 32'hxxxxxxxx; r_mis = 1'bx; r_waddr = 8'hxx; r_wdata = 32'hxxxxxxxx;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (mem_wenable) begin
                r_wcnt++;
                r_wcyc  = n;
                r_waddr = mem_address;
                r_wdata = mem_wdata;
            end
            if (resp_valid) begin
                r_lat   = n;
                r_rdata = resp_rdata;
                r_mis   = misaligned;
                break;
            end
            if (req_ready || resp_rdata !== 32'h0 || misaligned !== 1'b0)
                r_stray++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        #2;
        checks++;
        if ({resp_valid, misaligned, mem_wenable} !== 3'b000 || resp_rdata !== 32'h0 ||
            mem_address !== 8'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b mis=%b wen=%b rdata=%h addr=%h wdata=%h, required all 0",
                     resp_valid, misaligned, mem_wenable, resp_rdata, mem_address, mem_wdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_wenable !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b wen=%b, required 1 0 0",
                     req_ready, resp_valid, mem_wenable);
        end
    endtask

    task automatic test_word_store;
        do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
        checks++;
        if (r_wcnt != 1 || r_wcyc != 1 || r_waddr !== 8'h04 || r_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_write: cnt=%0d cyc=%0d addr=%h data=%h, required 1 1 04 deadbeef",
                     r_wcnt, r_wcyc, r_waddr, r_wdata);
        end
        checks++;
        if (r_lat != 2 || r_mis !== 1'b0 || r_rdata !== 32'h0 || r_stray != 0) begin
            errors++;
            $display("FAIL sw_resp: lat=%0d mis=%b rdata=%h stray=%0d, required 2 0 0 0",
                     r_lat, r_mis, r_rdata, r_stray);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem: got %h, required deadbeef", mem[4]);
        end
    endtask

    task automatic test_loads;
        logic        we_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sz_t  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
        logic        un_t  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [9:0]  ad_t  [6] = '{10'h013, 10'h013, 10'h012, 10'h010, 10'h010, 10'h010};
        logic [31:0] ex_t  [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                                   32'h0000BEEF, 32'hDEADBEEF, 32'hFFFFFFEF};
        for (int i = 0; i < 6; i++) begin
            do_req(we_t[i], sz_t[i], un_t[i], ad_t[i], 32'h0);
            checks++;
            if (r_lat != 2 || r_rdata !== ex_t[i] || r_mis !== 1'b0 || r_wcnt != 0 || r_stray != 0) begin
                errors++;
                $display("FAIL load_%0d: lat=%0d rdata=%h mis=%b wcnt=%0d stray=%0d, required 2 %h 0 0 0",
                         i, r_lat, r_rdata, r_mis, r_wcnt, r_stray, ex_t[i]);
            end
        end
    endtask

    task automatic test_subword_store;
        preload(8'h02, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 10'h009, 32'hFFFFFFAB);
        checks++;
        if (r_wcnt != 1 || r_wcyc != 2 || r_waddr !== 8'h02 || r_wdata !== 32'h1122AB44) begin
            errors++;
            $display("FAIL sb_write: cnt=%0d cyc=%0d addr=%h data=%h, required 1 2 02 1122ab44",
                     r_wcnt, r_wcyc, r_waddr, r_wdata);
        end
        checks++;
        if (r_lat != 3 || r_mis !== 1'b0 || r_rdata !== 32'h0 || r_stray != 0) begin
            errors++;
            $display("FAIL sb_resp: lat=%0d mis=%b rdata=%h stray=%0d, required 3 0 0 0",
                     r_lat, r_mis, r_rdata, r_stray);
        end
        preload(8'h02, 32'h11223344);
        do_req(1'b1, 2'b01, 1'b0, 10'h00A, 32'h99995566);
        checks++;
        if (r_wcnt != 1 || r_wcyc != 2 || r_wdata !== 32'h55663344 || r_lat != 3) begin
            errors++;
            $display("FAIL sh_write: cnt=%0d cyc=%0d data=%h lat=%0d, required 1 2 55663344 3",
                     r_wcnt, r_wcyc, r_wdata, r_lat);
        end
    endtask

    task automatic test_faults;
        logic        we_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz_t [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [9:0]  ad_t [4] = '{10'h006, 10'h005, 10'h010, 10'h011};
        for (int i = 0; i < 4; i++) begin
            do_req(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'hCAFEF00D);
            checks++;
            if (r_lat != 1 || r_mis !== 1'b1 || r_rdata !== 32'h0 || r_wcnt != 0) begin
                errors++;
                $display("FAIL fault_%0d: lat=%0d mis=%b rdata=%h wcnt=%0d, required 1 1 0 0",
                         i, r_lat, r_mis, r_rdata, r_wcnt);
            end
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fault_mem: got %h, required deadbeef", mem[4]);
        end
    endtask

    task automatic test_reset_abort;
        logic found = 1'b0;
        logic seen_resp = 1'b0;
        logic seen_wen = 1'b0;
        preload(8'h02, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 10'h008; req_wdata = 32'h00000077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (mem_wenable) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_write: wenable never seen, required within 5 cycles");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_wenable !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: wen=%b valid=%b, required 0 0", mem_wenable, resp_valid);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
            if (mem_wenable) seen_wen = 1'b1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
            if (mem_wenable) seen_wen = 1'b1;
        end
        checks++;
        if (seen_resp || seen_wen || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_after: resp_seen=%b wen_seen=%b ready=%b, required 0 0 1",
                     seen_resp, seen_wen, req_ready);
        end
        do_req(1'b0, 2'b10, 1'b0, 10'h008, 32'h0);
        checks++;
        if (r_lat != 2 || r_rdata !== 32'h11223344) begin
            errors++;
            $display("FAIL abort_readback: lat=%0d rdata=%h, required 2 11223344", r_lat, r_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic        rdy [1:6];
        logic        rv  [1:6];
        logic [31:0] rd  [1:6];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 10'h010; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_addr = 10'h008;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            rdy[n] = req_ready;
            rv[n]  = resp_valid;
            rd[n]  = resp_rdata;
            if (n == 4) req_valid = 1'b0;
        end
        checks++;
        if ({rdy[1], rdy[2], rdy[3], rdy[4], rdy[5], rdy[6]} !== 6'b001001) begin
            errors++;
            $display("FAIL b2b_ready: got %b%b%b%b%b%b, required 001001",
                     rdy[1], rdy[2], rdy[3], rdy[4], rdy[5], rdy[6]);
        end
        checks++;
        if ({rv[1], rv[2], rv[3], rv[4], rv[5], rv[6]} !== 6'b010010) begin
            errors++;
            $display("FAIL b2b_valid: got %b%b%b%b%b%b, required 010010",
                     rv[1], rv[2], rv[3], rv[4], rv[5], rv[6]);
        end
        checks++;
        if (rd[2] !== 32'hDEADBEEF || rd[5] !== 32'h11223344) begin
            errors++;
            $display("FAIL b2b_data: first=%h second=%h, required deadbeef 11223344", rd[2], rd[5]);
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_loads();
        test_subword_store();
        test_faults();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
